// File: rtl/ppe_rr_pipe.sv
// Two-stage pipelined programmable priority encoder with valid/ready flow control.
// Grants the lowest request at or above a pointer, with wrap, using an external or an internal round-robin pointer.
module ppe_rr_pipe #(
    parameter  int W  = 1024,
    localparam int LW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  req,
    input  logic [LW-1:0] p_enc,
    input  logic          mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] o_value,
    output logic [LW-1:0] o_value_inc,
    output logic          o_any,
    output logic [LW-1:0] rr_ptr
);

    logic          s1_valid;
    logic [W-1:0]  s1_req;
    logic [LW-1:0] s1_p_enc;
    logic          s1_mode;

    logic          accept;
    logic          s1_adv;

    logic [LW-1:0] ptr;
    logic [W-1:0]  masked;
    logic [LW-1:0] grant_m;
    logic [LW-1:0] grant_r;
    logic [LW-1:0] grant;
    logic [LW-1:0] grant_inc;
    logic          any;

    // S1 may be refilled whenever it is empty or is moving into S2 this cycle.
    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign s1_adv   = s1_valid && (!out_valid || out_ready);

    // The pointer is resolved here, so back-to-back RR transactions see the freshest rr_ptr.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        ptr     = s1_mode ? rr_ptr : s1_p_enc;
        masked  = s1_req & ({W{1'b1}} << ptr);
        grant_m = '0;
        grant_r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (masked[i]) grant_m = LW'(i);
            if (s1_req[i]) grant_r = LW'(i);
        end
        grant     = (|masked) ? grant_m : grant_r;
        grant_inc = grant + LW'(1);
        any       = |s1_req;
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
            s1_p_enc <= '0;
            s1_mode  <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_req   <= req;
            s1_p_enc <= p_enc;
            s1_mode  <= mode;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            o_value     <= '0;
            o_value_inc <= '0;
            o_any       <= 1'b0;
            rr_ptr      <= '0;
        end else if (s1_adv) begin
            out_valid   <= 1'b1;
            o_value     <= grant;
            o_value_inc <= grant_inc;
            o_any       <= any;
            if (s1_mode && any) rr_ptr <= grant_inc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ppe_rr_pipe.sv
// Self-checking bench for ppe_rr_pipe: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic scored against an in-order reference model (W=16), plus a W=1024 smoke test.
module tb_ppe_rr_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // W = 16 instance
    logic        in_valid, in_ready, mode, out_valid, out_ready, o_any;
    logic [15:0] req;
    logic [3:0]  p_enc, o_value, o_value_inc, rr_ptr;

    ppe_rr_pipe #(.W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .req(req),
        .p_enc(p_enc), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .o_value(o_value), .o_value_inc(o_value_inc), .o_any(o_any), .rr_ptr(rr_ptr)
    );

    // W = 1024 instance
    logic          in_valid_b, in_ready_b, mode_b, out_valid_b, out_ready_b, o_any_b;
    logic [1023:0] req_b;
    logic [9:0]    p_enc_b, o_value_b, o_value_inc_b, rr_ptr_b;

    ppe_rr_pipe #(.W(1024)) dut_big (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .req(req_b),
        .p_enc(p_enc_b), .mode(mode_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .o_value(o_value_b), .o_value_inc(o_value_inc_b), .o_any(o_any_b), .rr_ptr(rr_ptr_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walk upward from the pointer with wrap; first set bit wins.
    function automatic logic [4:0] ref_grant(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (p + k) % 16;
            if (r[idx]) return {1'b1, 4'(idx)};
        end
        return 5'b0;
    endfunction

    typedef struct {
        logic [3:0] val;
        logic [3:0] inc;
        logic       any;
        logic [3:0] rr;
    } exp_t;

    exp_t sb[$];
    int   model_rr = 0;

    // One cycle: score the outputs, drive inputs at the negedge, record the handshakes of the next edge.
    task automatic step(input logic iv, input logic [15:0] r, input logic [3:0] p, input logic m,
                        input logic ordy, output logic acc, output logic rdy);
        @(negedge clk);
        check("no_spurious_out", 32'(out_valid && sb.size() == 0), 0);
        if (out_valid && sb.size() > 0) begin
            check("sb_value", 32'(o_value), 32'(sb[0].val));
            check("sb_value_inc", 32'(o_value_inc), 32'(sb[0].inc));
            check("sb_any", 32'(o_any), 32'(sb[0].any));
            check("sb_rr_ptr", 32'(rr_ptr), 32'(sb[0].rr));
        end
        in_valid = iv; req = r; p_enc = p; mode = m; out_ready = ordy;
        #1;
        rdy = in_ready;
        acc = iv && in_ready;
        if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
            exp_t       e;
            logic [4:0] g;
            g     = ref_grant(r, m ? model_rr : int'(p));
            e.val = g[3:0];
            e.inc = 4'((int'(g[3:0]) + 1) % 16);
            e.any = g[4];
            if (m && g[4]) model_rr = int'(e.inc);
            e.rr  = 4'(model_rr);
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        logic a, r;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, a, r);
    endtask

    task automatic drain();
        logic a, r;
        for (int i = 0; i < 12 && sb.size() > 0; i++) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, a, r);
        check("drain_empty", 32'(sb.size()), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 0; out_ready = 1; req = '0; p_enc = '0; mode = 0;
        in_valid_b = 0; out_ready_b = 1; req_b = '0; p_enc_b = '0; mode_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        model_rr = 0;
    endtask

    typedef struct {
        logic        mode;
        logic [15:0] req;
        logic [3:0]  p;
        logic [3:0]  val;
        logic [3:0]  inc;
        logic        any;
        logic [3:0]  rr;
    } vec_t;

    vec_t vecs[10];

    task automatic big_txn(input int bit_idx, input int p, input int exp_val);
        int n;
        @(negedge clk);
        req_b = '0; req_b[bit_idx] = 1'b1; p_enc_b = 10'(p); mode_b = 0;
        in_valid_b = 1; out_ready_b = 1;
        @(negedge clk);
        in_valid_b = 0;
        n = 0;
        while (!out_valid_b && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("big_timeout", 32'(out_valid_b), 1);
        check("big_value", 32'(o_value_b), 32'(exp_val));
        check("big_value_inc", 32'(o_value_inc_b), 32'((exp_val + 1) % 1024));
        check("big_any", 32'(o_any_b), 1);
    endtask

    initial begin
        logic        acc, rdy;
        logic        cur_iv, cur_m, ordy;
        logic [15:0] cur_r;
        logic [3:0]  cur_p;
        int          ti, accepted;

        vecs[0] = '{1'b0, 16'h8421, 4'd6,  4'd10, 4'd11, 1'b1, 4'd0};
        vecs[1] = '{1'b0, 16'h8421, 4'd11, 4'd15, 4'd0,  1'b1, 4'd0};
        vecs[2] = '{1'b0, 16'h0003, 4'd5,  4'd0,  4'd1,  1'b1, 4'd0};
        vecs[3] = '{1'b0, 16'h0000, 4'd9,  4'd0,  4'd1,  1'b0, 4'd0};
        vecs[4] = '{1'b1, 16'h0000, 4'd7,  4'd0,  4'd1,  1'b0, 4'd0};
        vecs[5] = '{1'b0, 16'h0011, 4'd3,  4'd4,  4'd5,  1'b1, 4'd0};
        vecs[6] = '{1'b1, 16'h0011, 4'd9,  4'd0,  4'd1,  1'b1, 4'd1};
        vecs[7] = '{1'b1, 16'h0011, 4'd0,  4'd4,  4'd5,  1'b1, 4'd5};
        vecs[8] = '{1'b1, 16'h0011, 4'd2,  4'd0,  4'd1,  1'b1, 4'd1};
        vecs[9] = '{1'b0, 16'h8000, 4'd15, 4'd15, 4'd0,  1'b1, 4'd1};

        rst_n = 1'b0;
        do_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_value", 32'(o_value), 0);
        check("rst_value_inc", 32'(o_value_inc), 0);
        check("rst_any", 32'(o_any), 0);
        check("rst_rr_ptr", 32'(rr_ptr), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Directed vectors, one at a time, with latency checks.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].req, vecs[i].p, vecs[i].mode, 1'b1, acc, rdy);
            check("vec_accept", 32'(acc), 1);
            step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, acc, rdy);
            check("vec_latency_early", 32'(out_valid), 0);
            step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, acc, rdy);
            check("vec_out_valid", 32'(out_valid), 1);
            check("vec_value", 32'(o_value), 32'(vecs[i].val));
            check("vec_value_inc", 32'(o_value_inc), 32'(vecs[i].inc));
            check("vec_any", 32'(o_any), 32'(vecs[i].any));
            check("vec_rr_ptr", 32'(rr_ptr), 32'(vecs[i].rr));
        end
        drain();

        // Three back-to-back RR transactions from reset.
        do_reset();
        step(1'b1, 16'h0011, 4'h0, 1'b1, 1'b1, acc, rdy);
        step(1'b1, 16'h0011, 4'h0, 1'b1, 1'b1, acc, rdy);
        step(1'b1, 16'h0011, 4'h0, 1'b1, 1'b1, acc, rdy);
        check("b2b_value0", 32'(o_value), 0);
        check("b2b_rr0", 32'(rr_ptr), 1);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, acc, rdy);
        check("b2b_value1", 32'(o_value), 4);
        check("b2b_rr1", 32'(rr_ptr), 5);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, acc, rdy);
        check("b2b_value2", 32'(o_value), 0);
        check("b2b_rr2", 32'(rr_ptr), 1);
        drain();

        // Backpressure: five transactions, out_ready low during cycles 2..6.
        do_reset();
        ti = 0;
        accepted = 0;
        for (int c = 0; c < 40 && (ti < 5 || sb.size() > 0); c++) begin
            ordy = !(c >= 2 && c <= 6);
            step(ti < 5, 16'hFFFF, 4'(ti), 1'b0, ordy, acc, rdy);
            if (c >= 2 && c <= 6) begin
                check("bp_in_ready_low", 32'(rdy), 0);
                check("bp_hold_value", 32'(o_value), 0);
            end
            if (acc) ti++;
            if (c == 6) accepted = ti;
        end
        check("bp_accepted_before_release", 32'(accepted), 2);
        check("bp_all_sent", 32'(ti), 5);
        drain();

        // Reset with two transactions in flight.
        do_reset();
        step(1'b1, 16'h0100, 4'd2, 1'b1, 1'b0, acc, rdy);
        step(1'b1, 16'h0003, 4'd0, 1'b0, 1'b0, acc, rdy);
        check("mid_second_accept", 32'(acc), 1);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, acc, rdy);
        check("mid_rr_before", 32'(rr_ptr), 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_rr_ptr", 32'(rr_ptr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        model_rr = 0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 1);
        idle(5);

        // Randomized traffic against the reference model.
        do_reset();
        cur_iv = 0; cur_r = '0; cur_p = '0; cur_m = 0;
        for (int c = 0; c < 600; c++) begin
            if (!cur_iv && $urandom_range(0, 3) != 0) begin
                cur_iv = 1;
                cur_r  = 16'($urandom) & 16'($urandom);
                if ($urandom_range(0, 7) == 0) cur_r = '0;
                cur_p  = 4'($urandom);
                cur_m  = 1'($urandom);
            end
            step(cur_iv, cur_r, cur_p, cur_m, $urandom_range(0, 9) < 7, acc, rdy);
            if (acc) cur_iv = 0;
        end
        drain();

        // W = 1024 smoke.
        do_reset();
        big_txn(1023, 1023, 1023);
        big_txn(1023, 0, 1023);
        big_txn(5, 1000, 5);
        big_txn(512, 512, 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
